ysyx_22040125_sequencer: RTL and testbench

YSYX_22040125_SEQUENCER -- requirements
Module: ysyx_22040125_sequencer

---
 rtl/ysyx_22040125_sequencer.sv | 140 ++++++++++++++
 tb/tb_ysyx_22040125_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040125_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with
// bus-timeout watchdog and a 64-bit retired-instruction counter.
module ysyx_22040125_sequencer (
  input  logic        clk,
  input  logic        rst,
  output logic        ifetch_req,
  input  logic        ifetch_ack,
  output logic        ir_wen,
  input  logic        dec_data_ren,
  input  logic        dec_data_wen,
  input  logic        dec_reg_wen,
  input  logic        dec_halt,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        rf_wen,
  output logic        pc_wen,
  output logic        halted,
  output logic        err,
  output logic [63:0] instret,
  output logic [2:0]  state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [63:0] instret_q, instret_d;

  logic in_fetch, in_mem, in_wb;
  logic wait_max, waiting, entering;

  assign in_fetch = (state_q == S_FETCH);
  assign in_mem   = (state_q == S_MEM);
  assign in_wb    = (state_q == S_WB);
  assign wait_max = (wait_q == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      err_q     <= 1'b0;
      instret_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      instret_q <= instret_d;
    end
  end

  // An ack in the last allowed wait cycle still wins over the timeout.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH: begin
        if (ifetch_ack) begin
          state_d = S_DECODE;
        end else if (wait_max) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_DECODE: state_d = dec_halt ? S_HALT : S_EXEC;
      S_EXEC:
        state_d = (dec_data_ren | dec_data_wen) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ack) begin
          state_d = S_WB;
        end else if (wait_max) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_WB:   state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end
    endcase
  end

  assign waiting  = (in_fetch & ~ifetch_ack) | (in_mem & ~mem_ack);
  assign entering = (state_d != state_q) &
                    ((state_d == S_FETCH) | (state_d == S_MEM));

  always_comb begin
    wait_d = wait_q;
    if (entering) begin
      wait_d = 8'd0;
    end else if (waiting) begin
      wait_d = wait_q + 8'd1;
    end
  end

  assign instret_d = instret_q + {63'd0, in_wb};

  // Reset masks every output except the debug state.
  always_comb begin
    ifetch_req = 1'b0;
    ir_wen     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    rf_wen     = 1'b0;
    pc_wen     = 1'b0;
    halted     = 1'b0;
    err        = 1'b0;
    instret    = 64'd0;
    state      = state_q;
    if (!rst) begin
      err     = err_q;
      instret = instret_q;
      unique case (1'b1)
        in_fetch: begin
          ifetch_req = 1'b1;
          ir_wen     = ifetch_ack;
        end
        in_mem: begin
          mem_req = 1'b1;
          mem_we  = dec_data_wen;
        end
        in_wb: begin
          pc_wen = 1'b1;
          rf_wen = dec_reg_wen & ~dec_data_wen;
        end
        (state_q == S_HALT): halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040125_sequencer.sv
// Directed + randomized bench for the sequencer; expectations come from
// an instruction-level timeline model (phase lengths from ack delays).
module tb_ysyx_22040125_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifetch_req, ifetch_ack, ir_wen;
  logic        dec_data_ren, dec_data_wen, dec_reg_wen, dec_halt;
  logic        mem_req, mem_we, mem_ack;
  logic        rf_wen, pc_wen, halted, err;
  logic [63:0] instret;
  logic [2:0]  state;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_instret = 64'd0;

  ysyx_22040125_sequencer dut (
    .clk(clk), .rst(rst),
    .ifetch_req(ifetch_req), .ifetch_ack(ifetch_ack),
    .ir_wen(ir_wen),
    .dec_data_ren(dec_data_ren), .dec_data_wen(dec_data_wen),
    .dec_reg_wen(dec_reg_wen), .dec_halt(dec_halt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .rf_wen(rf_wen), .pc_wen(pc_wen),
    .halted(halted), .err(err),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  // Vector order: ifetch_req ir_wen mem_req mem_we rf_wen pc_wen halted err
  task automatic expect_cyc(input string tag, input logic [7:0] ev,
                            input bit cs, input logic [2:0] es);
    chk({tag, ".out"},
        {56'd0, ifetch_req, ir_wen, mem_req, mem_we,
         rf_wen, pc_wen, halted, err}, {56'd0, ev});
    if (cs) chk({tag, ".state"}, {61'd0, state}, {61'd0, es});
    chk({tag, ".instret"}, instret, exp_instret);
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifetch_ack = rb(); mem_ack = rb();
    dec_data_ren = rb(); dec_data_wen = rb();
    dec_reg_wen = rb(); dec_halt = rb();
    exp_instret = 64'd0;
    #1 expect_cyc("rst0", 8'h00, 1'b0, 3'd0);
    @(negedge clk);
    ifetch_ack = 1'b1; mem_ack = 1'b1;
    #1 expect_cyc("rst1", 8'h00, 1'b1, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    dec_halt = 1'b0;
  endtask

  // One instruction: fw wait cycles before fetch ack, mw before mem ack.
  task automatic run_instr(input logic ren, input logic wen,
                           input logic regw, input int fw, input int mw);
    dec_data_ren = ren; dec_data_wen = wen;
    dec_reg_wen = regw; dec_halt = 1'b0;
    for (int i = 0; i <= fw; i++) begin
      if (i > 0) @(negedge clk);
      ifetch_ack = (i == fw); mem_ack = rb();
      #1 expect_cyc("fetch", {1'b1, i == fw, 6'b0}, 1'b1, 3'd0);
    end
    @(negedge clk);
    ifetch_ack = rb(); mem_ack = rb();
    #1 expect_cyc("decode", 8'h00, 1'b1, 3'd1);
    @(negedge clk);
    ifetch_ack = rb(); mem_ack = rb();
    #1 expect_cyc("exec", 8'h00, 1'b1, 3'd2);
    if (ren | wen) begin
      for (int j = 0; j <= mw; j++) begin
        @(negedge clk);
        mem_ack = (j == mw); ifetch_ack = rb();
        #1 expect_cyc("mem", {2'b00, 1'b1, wen, 4'b0}, 1'b1, 3'd3);
      end
    end
    @(negedge clk);
    ifetch_ack = rb(); mem_ack = rb();
    #1 expect_cyc("wb", {4'b0, regw & ~wen, 1'b1, 2'b00}, 1'b1, 3'd4);
    exp_instret = exp_instret + 64'd1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ifetch_ack = 1'b0; mem_ack = 1'b0;
    dec_data_ren = 1'b0; dec_data_wen = 1'b0;
    dec_reg_wen = 1'b0; dec_halt = 1'b0;
    do_reset();

    // ALU ops with immediate acks: pc_wen at cycles 4, 8, 12
    for (int k = 0; k < 3; k++) run_instr(1'b0, 1'b0, 1'b1, 0, 0);
    #1 chk("instret3", instret, 64'd3);

    // Load with 3 wait cycles, then store with ren=wen=1
    run_instr(1'b1, 1'b0, 1'b1, 0, 3);
    run_instr(1'b1, 1'b1, 1'b1, 0, 2);

    for (int k = 0; k < 30; k++)
      run_instr(rb(), rb(), rb(), $urandom_range(0, 4),
                $urandom_range(0, 4));

    // Ack in the final permitted wait cycle still proceeds normally
    run_instr(1'b1, 1'b0, 1'b1, 255, 255);

    // Counter wrap
    #1 force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret_q;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    run_instr(1'b0, 1'b0, 1'b1, 1, 0);
    #1 chk("wrap", instret, 64'd0);

    // ebreak: FETCH, DECODE, HALT; instret frozen
    do_reset();
    run_instr(1'b0, 1'b0, 1'b1, 0, 0);
    ifetch_ack = 1'b1; dec_halt = 1'b1;
    #1 expect_cyc("h.fetch", 8'hC0, 1'b1, 3'd0);
    @(negedge clk);
    #1 expect_cyc("h.decode", 8'h00, 1'b1, 3'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ifetch_ack = rb(); mem_ack = rb(); dec_halt = rb();
      #1 expect_cyc("h.halt", 8'h02, 1'b1, 3'd5);
    end
    do_reset();
    ifetch_ack = 1'b0;
    #1 expect_cyc("h.restart", 8'h80, 1'b1, 3'd0);

    // Fetch timeout after 256 cycles without ack
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      ifetch_ack = 1'b0; mem_ack = rb();
      #1 expect_cyc("to.fetch", 8'h80, 1'b1, 3'd0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ifetch_ack = rb(); mem_ack = rb();
      #1 expect_cyc("to.halt", 8'h03, 1'b1, 3'd5);
    end

    // Reset mid-MEM drops the access
    do_reset();
    run_instr(1'b0, 1'b0, 1'b1, 0, 0);
    dec_data_ren = 1'b1; dec_data_wen = 1'b0; dec_reg_wen = 1'b1;
    ifetch_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    #1 expect_cyc("mm.mem", 8'h20, 1'b1, 3'd3);
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1;
    exp_instret = 64'd0;
    #1 expect_cyc("mm.rst", 8'h00, 1'b1, 3'd3);
    @(negedge clk);
    rst = 1'b0; ifetch_ack = 1'b0;
    #1 expect_cyc("mm.after", 8'h80, 1'b1, 3'd0);
    @(negedge clk);
    #1 expect_cyc("mm.after2", 8'h80, 1'b1, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
